tw_rom_sched: RTL

Sequencer for the 1024/64 twiddle-factor ROM bank. On a start pulse it optionally collects 8 horizontal twiddle words from an upstream stream and bursts them into the ROM's stage-0 buffer in the high-halves-then-low-halves order the ROM requires. It then steps the ROM through every compute stage by driving stage_counter, CEN (active-low) and the state code. It sits between the top-level FFT control and the ROM.

---
 rtl/tw_rom_sched_if.sv | 21 ++
 rtl/tw_rom_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tw_rom_sched_if.sv
// Upstream twiddle-word stream into the ROM sequencer.
// Master drives words; slave accepts them with tf_ready.
interface tw_rom_sched_if #(
  parameter int horizontal_DW = 64
);
  logic                     tf_valid;
  logic [horizontal_DW-1:0] tf_data;
  logic                     tf_ready;

  modport master (
    output tf_valid,
    output tf_data,
    input  tf_ready
  );

  modport slave (
    input  tf_valid,
    input  tf_data,
    output tf_ready
  );
endinterface

// File: rtl/tw_rom_sched.sv
// Twiddle ROM sequencer: optional 8-word load burst,
// then steps the ROM through every compute stage.
module tw_rom_sched #(
  parameter int SC_WIDTH      = 3,
  parameter int S_WIDTH       = 4,
  parameter int horizontal_DW = 64,
  parameter int STAGE_NUM     = 3,
  parameter int STAGE_LEN     = 256
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     load_en,
  input  logic                     halt,
  tw_rom_sched_if.slave            tf,
  output logic [horizontal_DW-1:0] horizontal_tf_out,
  output logic [1:0]               ROM6_w,
  output logic [SC_WIDTH-1:0]      stage_counter,
  output logic                     CEN,
  output logic [S_WIDTH-1:0]       state,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    BURST_HI = 3'd2,
    BURST_LO = 3'd3,
    RUN_EVEN = 3'd4,
    GAP      = 3'd5,
    RUN_ODD  = 3'd6,
    FIN      = 3'd7
  } st_t;

  st_t st;
  st_t st_n;

  logic [2:0]          wcnt;
  logic [2:0]          wcnt_n;
  logic [CW-1:0]       ccnt;
  logic [CW-1:0]       ccnt_n;
  logic [SC_WIDTH-1:0] sc_n;

  logic [horizontal_DW-1:0] tbuf [8];

  logic run;
  logic hs;
  logic last_cyc;
  logic last_stg;

  assign run         = (st == RUN_EVEN) || (st == RUN_ODD);
  assign tf.tf_ready = (st == COLLECT);
  assign hs          = tf.tf_valid & tf.tf_ready;
  assign CEN         = run ? halt : 1'b1;
  assign busy        = (st != IDLE);
  assign done        = (st == FIN);
  assign state       = S_WIDTH'(st);
  assign last_cyc    = (ccnt == CW'(STAGE_LEN - 1));
  assign last_stg    = (stage_counter == SC_WIDTH'(STAGE_NUM - 1));

  always_comb begin
    st_n   = st;
    wcnt_n = wcnt;
    ccnt_n = ccnt;
    sc_n   = stage_counter;
    unique case (st)
      IDLE: begin
        if (start) begin
          if (load_en) begin
            st_n   = COLLECT;
            wcnt_n = '0;
          end else begin
            st_n   = RUN_EVEN;
            sc_n   = '0;
            ccnt_n = '0;
          end
        end
      end
      COLLECT: begin
        // wcnt wraps to 0 on the 8th word, ready for the burst index
        if (hs) begin
          wcnt_n = wcnt + 3'd1;
          if (wcnt == 3'd7) st_n = BURST_HI;
        end
      end
      BURST_HI: begin
        wcnt_n = wcnt + 3'd1;
        if (wcnt == 3'd3) begin
          st_n   = BURST_LO;
          wcnt_n = '0;
        end
      end
      BURST_LO: begin
        wcnt_n = wcnt + 3'd1;
        if (wcnt == 3'd3) begin
          st_n   = RUN_EVEN;
          wcnt_n = '0;
          sc_n   = '0;
          ccnt_n = '0;
        end
      end
      RUN_EVEN,
      RUN_ODD: begin
        if (!halt) begin
          ccnt_n = ccnt + CW'(1);
          if (last_cyc) begin
            ccnt_n = '0;
            st_n   = last_stg ? FIN : GAP;
          end
        end
      end
      GAP: begin
        sc_n = stage_counter + SC_WIDTH'(1);
        st_n = sc_n[0] ? RUN_ODD : RUN_EVEN;
      end
      FIN: begin
        sc_n = '0;
        st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      st                <= IDLE;
      wcnt              <= '0;
      ccnt              <= '0;
      stage_counter     <= '0;
      ROM6_w            <= 2'd0;
      horizontal_tf_out <= '0;
    end else begin
      st                <= st_n;
      wcnt              <= wcnt_n;
      ccnt              <= ccnt_n;
      stage_counter     <= sc_n;
      ROM6_w            <= 2'd0;
      horizontal_tf_out <= '0;
      // Burst outputs are registered, so look ahead at the next slot
      unique case (1'b1)
        (st_n == BURST_HI): begin
          ROM6_w            <= 2'd1;
          horizontal_tf_out <= tbuf[{wcnt_n[1:0], 1'b0}];
        end
        (st_n == BURST_LO): begin
          ROM6_w            <= 2'd2;
          horizontal_tf_out <= tbuf[{wcnt_n[1:0], 1'b1}];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst && hs) tbuf[wcnt] <= tf.tf_data;
  end

endmodule
